// File: rtl/control_pkg.sv
// Shared types and constants for the multicycle control unit: FSM state
// encoding, ALU operation codes and opcode classes.
package control_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    OPERAND   = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_CMP  = 3'b010;
  localparam logic [2:0] ALU_FADD = 3'b100;
  localparam logic [2:0] ALU_FSUB = 3'b101;
  localparam logic [2:0] ALU_NOP  = 3'b111;

  localparam logic [1:0] CLS_REG    = 2'b00;
  localparam logic [1:0] CLS_IMM    = 2'b01;
  localparam logic [1:0] CLS_BRANCH = 2'b10;
  localparam logic [1:0] CLS_FP     = 2'b11;

  // Opcode[0] picks the subtract flavour within the integer and FP classes.
  function automatic logic [2:0] alu_op_of(input logic [2:0] op);
    logic [2:0] res;
    case (op[2:1])
      CLS_REG, CLS_IMM: res = {2'b00, op[0]};
      CLS_BRANCH:       res = ALU_CMP;
      default:          res = {2'b10, op[0]};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that flags the last cycle of a MEM_LAT-cycle wait.
// Loaded with MEM_LAT-1 on entry; terminal count (zero) marks the last cycle.
module mem_wait_counter #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic last
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle instruction sequencer for the 13-bit word processor; owns the PC.
// Define FP_EN to execute class-11 (FP) opcodes; otherwise they retire as NOPs.
//
// state     | meaning
// FETCH     | instruction read from memory at PC, MEM_LAT cycles
// DECODE    | latch opcode, choose path
// OPERAND   | data operand read, MEM_LAT cycles
// EXECUTE   | ALU op driven; branches update PC here
// WRITEBACK | result write to memory, MEM_LAT cycles, then PC+1
module multicycle_control
  import control_pkg::*;
#(
  parameter int              PC_W     = 13,
  parameter int              MEM_LAT  = 1,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      Opcode,
  output logic [PC_W-1:0] PC,
  output logic            InstructionTypeSelect,
  output logic [2:0]      ALU_Op,
  output logic            WriteFlag,
  output logic            ReadFlag,
  output logic            instructionControl
);

  state_t          state, state_nx;
  logic [2:0]      op_q;
  logic [PC_W-1:0] pc_q, pc_nx;
  logic            last;
  logic            load;
  logic            rd, wr, ic, its;
  logic [2:0]      alu;

  // Every state change re-arms the wait counter, so each access state
  // starts a fresh MEM_LAT count.
  assign load = (state_nx != state);

  mem_wait_counter #(
    .MEM_LAT(MEM_LAT)
  ) u_wait (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc_q  <= RESET_PC;
      op_q  <= '0;
    end else begin
      state <= state_nx;
      pc_q  <= pc_nx;
      if (state == DECODE) op_q <= Opcode;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    rd       = 1'b0;
    wr       = 1'b0;
    ic       = 1'b0;
    its      = 1'b0;
    alu      = ALU_NOP;
    case (state)
      FETCH: begin
        rd = 1'b1;
        ic = 1'b1;
        if (last) state_nx = DECODE;
      end
      DECODE: begin
        case (Opcode[2:1])
          CLS_REG:             state_nx = OPERAND;
          CLS_IMM, CLS_BRANCH: state_nx = EXECUTE;
          default: begin
`ifdef FP_EN
            state_nx = OPERAND;
`else
            state_nx = FETCH;
            pc_nx    = pc_q + PC_W'(1);
`endif
          end
        endcase
      end
      OPERAND: begin
        rd = 1'b1;
        if (last) state_nx = EXECUTE;
      end
      EXECUTE: begin
        alu = alu_op_of(op_q);
        its = (op_q[2:1] == CLS_IMM);
        // The word after a branch holds its operand, hence the skip of two.
        if (op_q[2:1] == CLS_BRANCH) begin
          pc_nx    = pc_q + PC_W'(2);
          state_nx = FETCH;
        end else begin
          state_nx = WRITEBACK;
        end
      end
      WRITEBACK: begin
        wr  = 1'b1;
        alu = alu_op_of(op_q);
        its = (op_q[2:1] == CLS_IMM);
        if (last) begin
          pc_nx    = pc_q + PC_W'(1);
          state_nx = FETCH;
        end
      end
      default: state_nx = FETCH;
    endcase
  end

  // Strobes are quiet while reset is held so no access leaks out mid-reset.
  assign PC                    = pc_q;
  assign ReadFlag              = rd & ~reset;
  assign WriteFlag             = wr & ~reset;
  assign instructionControl    = ic & ~reset;
  assign InstructionTypeSelect = its & ~reset;
  assign ALU_Op                = reset ? ALU_NOP : alu;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: three instances (MEM_LAT 1/3/2,
// one with RESET_PC near the top of memory); expected cycles queued per instruction.
module tb_multicycle_control;

  logic        clk;
  logic [2:0]  rst;
  logic [2:0]  Opcode;
  logic [12:0] pc_o  [3];
  logic        its_o [3];
  logic [2:0]  alu_o [3];
  logic        wr_o  [3];
  logic        rd_o  [3];
  logic        ic_o  [3];

  int n_vec;
  int n_err;

  typedef struct {
    logic [12:0] pc;
    logic        rd;
    logic        wr;
    logic        ic;
    logic        its;
    logic [2:0]  alu;
    logic        dec;
    logic [2:0]  op;
  } exp_t;

  exp_t q[$];

`ifdef FP_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  multicycle_control #(.PC_W(13), .MEM_LAT(1), .RESET_PC(13'h0000)) dut1 (
    .clk(clk), .reset(rst[0]), .Opcode(Opcode), .PC(pc_o[0]),
    .InstructionTypeSelect(its_o[0]), .ALU_Op(alu_o[0]), .WriteFlag(wr_o[0]),
    .ReadFlag(rd_o[0]), .instructionControl(ic_o[0]));

  multicycle_control #(.PC_W(13), .MEM_LAT(3), .RESET_PC(13'h0000)) dut3 (
    .clk(clk), .reset(rst[1]), .Opcode(Opcode), .PC(pc_o[1]),
    .InstructionTypeSelect(its_o[1]), .ALU_Op(alu_o[1]), .WriteFlag(wr_o[1]),
    .ReadFlag(rd_o[1]), .instructionControl(ic_o[1]));

  multicycle_control #(.PC_W(13), .MEM_LAT(2), .RESET_PC(13'h1FFE)) dutb (
    .clk(clk), .reset(rst[2]), .Opcode(Opcode), .PC(pc_o[2]),
    .InstructionTypeSelect(its_o[2]), .ALU_Op(alu_o[2]), .WriteFlag(wr_o[2]),
    .ReadFlag(rd_o[2]), .instructionControl(ic_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [12:0] pc, input logic rd, input logic wr,
                      input logic ic, input logic its, input logic [2:0] alu,
                      input logic dec, input logic [2:0] op);
    exp_t e;
    e.pc = pc; e.rd = rd; e.wr = wr; e.ic = ic; e.its = its;
    e.alu = alu; e.dec = dec; e.op = op;
    q.push_back(e);
  endtask

  // Reference sequence of one instruction; returns the PC after it retires.
  task automatic add_instr(input logic [2:0] op, input int lat, inout logic [12:0] pc);
    logic [1:0] cls;
    logic [2:0] alu;
    logic       imm;
    cls = op[2:1];
    imm = (cls == 2'b01);
    case (op)
      3'd0: alu = 3'b000;
      3'd1: alu = 3'b001;
      3'd2: alu = 3'b000;
      3'd3: alu = 3'b001;
      3'd4: alu = 3'b010;
      3'd5: alu = 3'b010;
      3'd6: alu = 3'b100;
      default: alu = 3'b101;
    endcase
    for (int i = 0; i < lat; i++) push(pc, 1, 0, 1, 0, 3'b111, 0, 3'd0);
    push(pc, 0, 0, 0, 0, 3'b111, 1, op);
    if (cls == 2'b11 && !FP) begin
      pc = pc + 13'd1;
      return;
    end
    if (cls == 2'b00 || cls == 2'b11)
      for (int i = 0; i < lat; i++) push(pc, 1, 0, 0, 0, 3'b111, 0, 3'd0);
    push(pc, 0, 0, 0, imm, alu, 0, 3'd0);
    if (cls == 2'b10) begin
      pc = pc + 13'd2;
      return;
    end
    for (int i = 0; i < lat; i++) push(pc, 0, 1, 0, imm, alu, 0, 3'd0);
    pc = pc + 13'd1;
  endtask

  // Called just after a rising edge; consumes n expected cycles (all if n<0).
  task automatic drain(input int sel, input int n);
    exp_t e;
    int   k;
    k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      e = q.pop_front();
      Opcode = e.dec ? e.op : 3'($urandom);
      @(negedge clk);
      chk($sformatf("d%0d.pc", sel),  32'(pc_o[sel]),  32'(e.pc));
      chk($sformatf("d%0d.rd", sel),  32'(rd_o[sel]),  32'(e.rd));
      chk($sformatf("d%0d.wr", sel),  32'(wr_o[sel]),  32'(e.wr));
      chk($sformatf("d%0d.ic", sel),  32'(ic_o[sel]),  32'(e.ic));
      chk($sformatf("d%0d.its", sel), 32'(its_o[sel]), 32'(e.its));
      chk($sformatf("d%0d.alu", sel), 32'(alu_o[sel]), 32'(e.alu));
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic reset_dut(input int sel, input logic [12:0] rpc);
    rst[sel] = 1'b1;
    @(posedge clk);
    #1;
    chk($sformatf("d%0d.rst_pc", sel),  32'(pc_o[sel]),  32'(rpc));
    chk($sformatf("d%0d.rst_rd", sel),  32'(rd_o[sel]),  32'd0);
    chk($sformatf("d%0d.rst_wr", sel),  32'(wr_o[sel]),  32'd0);
    chk($sformatf("d%0d.rst_ic", sel),  32'(ic_o[sel]),  32'd0);
    chk($sformatf("d%0d.rst_alu", sel), 32'(alu_o[sel]), 32'h7);
    rst[sel] = 1'b0;
  endtask

  initial begin
    logic [12:0] pc;
    n_vec  = 0;
    n_err  = 0;
    rst    = 3'b111;
    Opcode = 3'd0;
    repeat (2) @(posedge clk);
    #1;

    // MEM_LAT=1: every opcode once
    reset_dut(0, 13'h0000);
    pc = 13'h0000;
    for (int o = 0; o < 8; o++) add_instr(3'(o), 1, pc);
    add_instr(3'b001, 1, pc);
    drain(0, -1);

    // Branch wraps from the top of memory
    reset_dut(2, 13'h1FFE);
    pc = 13'h1FFE;
    add_instr(3'b100, 2, pc);
    add_instr(3'b010, 2, pc);
    drain(2, -1);

    // PC+1 wraps from 13'h1FFF
    reset_dut(2, 13'h1FFE);
    pc = 13'h1FFE;
    add_instr(3'b010, 2, pc);
    add_instr(3'b011, 2, pc);
    add_instr(3'b001, 2, pc);
    drain(2, -1);

    // MEM_LAT=3, then reset in the second WRITEBACK cycle
    reset_dut(1, 13'h0000);
    pc = 13'h0000;
    add_instr(3'b001, 3, pc);
    add_instr(3'b111, 3, pc);
    drain(1, -1);
    add_instr(3'b000, 3, pc);
    drain(1, 9);
    q.delete();
    rst[1] = 1'b1;
    Opcode = 3'($urandom);
    @(negedge clk);
    chk("d1.wr_in_rst", 32'(wr_o[1]), 32'd0);
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    pc = 13'h0000;
    add_instr(3'b011, 3, pc);
    add_instr(3'b101, 3, pc);
    drain(1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
